// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared SM constants and warp typedefs
package sm_pkg;

  localparam int NUM_WARP   = 8;
  localparam int DEPTH_WARP = 3;
  localparam int INST_WIDTH = 64;

  typedef logic [NUM_WARP-1:0]   warp_mask_t;
  typedef logic [DEPTH_WARP-1:0] wid_t;

endpackage

// File: rtl/sm_rr_arbiter.sv
// rtl/sm_rr_arbiter.sv - combinational round-robin find-first starting at ptr_i
module sm_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [W-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/sm_warp_scheduler.sv
// rtl/sm_warp_scheduler.sv - round-robin issue scheduler with single-entry output stage
module sm_warp_scheduler
  import sm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_WARP-1:0]   inst_buffer_has_data_i,
  input  logic [NUM_WARP-1:0]   sb_ready_i,
  output logic [NUM_WARP-1:0]   warp_to_issue_oh_o,
  input  logic [INST_WIDTH-1:0] ibuf_inst_i,
  input  logic [DEPTH_WARP-1:0] ibuf_wid_i,
  output logic                  ibuffer_signals_valid_o,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [INST_WIDTH-1:0] issue_inst_o,
  output logic [DEPTH_WARP-1:0] issue_wid_o,
  output logic                  sb_reserve_valid_o,
  output logic [DEPTH_WARP-1:0] sb_reserve_wid_o
);

  logic [INST_WIDTH-1:0] issue_inst_q, issue_inst_d;
  wid_t                  issue_wid_q, issue_wid_d;
  logic                  issue_valid_q, issue_valid_d;
  logic                  sb_reserve_valid_q, sb_reserve_valid_d;
  wid_t                  sb_reserve_wid_q, sb_reserve_wid_d;
  wid_t                  rr_ptr_q, rr_ptr_d;
  warp_mask_t            inflight_mask_q, inflight_mask_d;

  warp_mask_t eligible;
  warp_mask_t arb_onehot;
  wid_t       grant_idx;
  logic       arb_valid;
  logic       can_accept;
  logic       grant_valid;
  warp_mask_t grant_oh;

  assign eligible = inst_buffer_has_data_i & sb_ready_i & ~inflight_mask_q;

  sm_rr_arbiter #(
    .N(NUM_WARP),
    .W(DEPTH_WARP)
  ) u_rr_arbiter (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .onehot_o(arb_onehot),
    .idx_o   (grant_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    can_accept  = ~issue_valid_q | issue_ready_i;
    grant_valid = can_accept & arb_valid;
    grant_oh    = grant_valid ? arb_onehot : '0;
  end

  always_comb begin
    issue_inst_d       = issue_inst_q;
    issue_wid_d        = issue_wid_q;
    issue_valid_d      = issue_valid_q;
    sb_reserve_valid_d = 1'b0;
    sb_reserve_wid_d   = sb_reserve_wid_q;
    rr_ptr_d           = rr_ptr_q;
    // The mask only has to cover the cycle the scoreboard needs to register
    // the reservation, so it is simply last cycle's grant.
    inflight_mask_d    = grant_oh;
    if (grant_valid) begin
      issue_inst_d       = ibuf_inst_i;
      issue_wid_d        = grant_idx;
      issue_valid_d      = 1'b1;
      sb_reserve_valid_d = 1'b1;
      sb_reserve_wid_d   = grant_idx;
      rr_ptr_d           = (grant_idx == wid_t'(NUM_WARP - 1)) ? '0 : grant_idx + 1'b1;
    end else if (issue_ready_i && issue_valid_q) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_inst_q       <= '0;
      issue_wid_q        <= '0;
      issue_valid_q      <= 1'b0;
      sb_reserve_valid_q <= 1'b0;
      sb_reserve_wid_q   <= '0;
      rr_ptr_q           <= '0;
      inflight_mask_q    <= '0;
    end else begin
      issue_inst_q       <= issue_inst_d;
      issue_wid_q        <= issue_wid_d;
      issue_valid_q      <= issue_valid_d;
      sb_reserve_valid_q <= sb_reserve_valid_d;
      sb_reserve_wid_q   <= sb_reserve_wid_d;
      rr_ptr_q           <= rr_ptr_d;
      inflight_mask_q    <= inflight_mask_d;
    end
  end

  a_wid_match: assert property (@(posedge clk) disable iff (rst)
    grant_valid |-> (ibuf_wid_i == grant_idx));

  assign warp_to_issue_oh_o      = grant_oh;
  assign ibuffer_signals_valid_o = |grant_oh;
  assign issue_valid_o           = issue_valid_q;
  assign issue_inst_o            = issue_inst_q;
  assign issue_wid_o             = issue_wid_q;
  assign sb_reserve_valid_o      = sb_reserve_valid_q;
  assign sb_reserve_wid_o        = sb_reserve_wid_q;

endmodule

// File: doc/sm_warp_scheduler.md
Name: sm_warp_scheduler

Overview:
- Issue-stage warp scheduler directly downstream of sm_inst_buffer.
- Each cycle it picks one eligible warp, round-robin. Eligible means: the instruction buffer has data for the warp, the scoreboard clears it, and it is not already in flight.
- It drives the one-hot pop/select back to the instruction buffer and registers the selected instruction into a single-entry output stage.
- The output stage uses a valid/ready handshake toward operand collect, and the block issues a scoreboard reservation for every issued instruction.

Parameters:
NUM_WARP, 8 (`NUM_WARP), number of warp slots
DEPTH_WARP, 3 (`DEPTH_WARP), warp id width, equals clog2(NUM_WARP)
INST_WIDTH, 64 (`CODE_MEM_DATA_WIDTH), instruction word width

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
inst_buffer_has_data_i  input  NUM_WARP  per-warp non-empty flag from sm_inst_buffer
sb_ready_i  input  NUM_WARP  per-warp scoreboard clear: no RAW/WAW hazard on the warp's head instruction
warp_to_issue_oh_o  output  NUM_WARP  one-hot select/pop to sm_inst_buffer; all-zero means no pop
ibuf_inst_i  input  INST_WIDTH  head instruction of the warp selected by warp_to_issue_oh_o (combinational from buffer)
ibuf_wid_i  input  DEPTH_WARP  warp id accompanying ibuf_inst_i
ibuffer_signals_valid_o  output  1  OR-reduction of warp_to_issue_oh_o
issue_valid_o  output  1  output stage holds an instruction
issue_ready_i  input  1  operand collector accepts
issue_inst_o  output  INST_WIDTH  registered instruction
issue_wid_o  output  DEPTH_WARP  registered warp id
sb_reserve_valid_o  output  1  pulse: reserve destination in scoreboard
sb_reserve_wid_o  output  DEPTH_WARP  warp id for reservation

Behaviour:
- Reset (rst=1 at a clk edge): issue_valid_o=0, issue_inst_o=0, issue_wid_o=0, sb_reserve_valid_o=0, sb_reserve_wid_o=0, rr_ptr=0, inflight_mask=0. rst overrides all other activity in the same cycle; an in-flight output entry is dropped.
- Eligibility: eligible = inst_buffer_has_data_i & sb_ready_i & ~inflight_mask.
- can_accept = ~issue_valid_o | issue_ready_i. This is the standard pipeline bubble-collapse.
- Selection (combinational):
  - When can_accept, grant the first eligible warp searching upward from rr_ptr, wrapping modulo NUM_WARP.
  - warp_to_issue_oh_o is that one-hot; otherwise it is zero.
  - Exactly zero or one bit is set, never more.
- On the edge with a grant to warp w:
  - issue_inst_o<=ibuf_inst_i, issue_wid_o<=w, issue_valid_o<=1.
  - rr_ptr<=(w+1) mod NUM_WARP.
  - sb_reserve_valid_o<=1, sb_reserve_wid_o<=w.
  - inflight_mask[w]<=1.
- inflight_mask[w] clears one cycle later, after the scoreboard has registered the reservation. A warp is therefore never granted on two consecutive cycles; its minimum issue interval is 2 cycles.
- Without a grant:
  - If issue_ready_i and issue_valid_o: issue_valid_o<=0.
  - Otherwise the output holds its value, stable until accepted.
  - sb_reserve_valid_o<=0.
  - rr_ptr is unchanged.
- Latency: select to issue_valid_o is 1 cycle. Sustained throughput is 1 instr/cycle when at least 2 warps are eligible and issue_ready_i is held high.
- Backpressure: when issue_valid_o=1 and issue_ready_i=0, the output is frozen, no grant is made, and no pop occurs.
- Simultaneous accept and grant in the same cycle: the output is replaced by the new instruction with no bubble.
- ibuf_wid_i must equal the granted index. A mismatch is an assertion error; the granted index is the authoritative value.
- If no warp is eligible, the output drains normally and rr_ptr holds.
- rr_ptr wrap: from w=NUM_WARP-1, rr_ptr becomes 0.

Decomposition:
- Shared package sm_pkg:
  - NUM_WARP/DEPTH_WARP constants, mirroring define.sv.
  - typedef warp_mask_t logic[NUM_WARP-1:0].
  - typedef wid_t logic[DEPTH_WARP-1:0].
- Sub-module sm_rr_arbiter: parameterized, combinational round-robin find-first from pointer, with outputs onehot and index.

Test Plan:
1. Reset, then has_data=8'h00 -> warp_to_issue_oh_o=0, issue_valid_o=0 and sb_reserve_valid_o=0 for 10 cycles.
2. has_data=8'hFF, sb_ready=8'hFF, issue_ready=1 -> issue_wid_o sequence 0,1,...,7,0 on consecutive cycles; sb_reserve pulses every cycle.
3. Only warp 5 eligible, ready=1 -> grants on alternating cycles (inflight_mask), issue_valid_o toggles 1,0,1,0.
4. issue_valid_o=1 with wid=2, ready=0 for 4 cycles -> outputs stable, warp_to_issue_oh_o=0; ready=1 -> wid 3 appears the next cycle with no bubble.
5. has_data=8'h81, sb_ready=8'h01, rr_ptr=1 -> grant warp 0 (wrap), rr_ptr becomes 1; then sb_ready=8'h80 -> grant warp 7.
6. Assert rst while issue_valid_o=1 and ready=0 -> next cycle issue_valid_o=0, rr_ptr=0, inflight_mask=0.
